idma_txrx_read_mc: RTL and testbench

Multi-channel, multi-beat successor of the single-beat TXRX read backend in the iDMA transport layer. It accepts one read datapath request at a time and binds it to one of `NumChan` peripheral RX channels. It streams the request's beats into the realigning byte buffer with per-beat first/last masking, and returns exactly one response per request. The response carries sticky error and timeout status.

---
 rtl/idma_txrx_read_mc.sv | 143 ++++++++++++++
 tb/tb_idma_txrx_read_mc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_txrx_read_mc.sv
// idma_txrx_read_mc: multi-channel multi-beat read backend streaming RX beats into the realigning buffer
module idma_txrx_read_mc #(
    parameter int StrbWidth = 16,
    parameter int NumChan = 2,
    parameter int BeatWidth = 8,
    parameter int TimeoutCycles = 256,
    localparam int OW = $clog2(StrbWidth),
    localparam int CW = NumChan > 1 ? $clog2(NumChan) : 1,
    localparam int DW = 8 * StrbWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    r_dp_valid_i,
    output logic                    r_dp_ready_o,
    input  logic [CW-1:0]           r_dp_chan_i,
    input  logic [OW-1:0]           r_dp_offset_i,
    input  logic [OW-1:0]           r_dp_tailer_i,
    input  logic [OW-1:0]           r_dp_shift_i,
    input  logic [BeatWidth-1:0]    r_dp_beats_i,
    input  logic [NumChan-1:0]      rx_valid_i,
    output logic [NumChan-1:0]      rx_ready_o,
    input  logic [NumChan*DW-1:0]   rx_data_i,
    input  logic [NumChan-1:0]      rx_err_i,
    output logic [DW-1:0]           buffer_in_o,
    output logic [StrbWidth-1:0]    buffer_in_valid_o,
    input  logic [StrbWidth-1:0]    buffer_in_ready_i,
    output logic                    r_dp_rsp_valid_o,
    input  logic                    r_dp_rsp_ready_i,
    output logic [1:0]              r_dp_rsp_resp_o
);
    localparam int SW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, RESP} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        chan_q, chan_d;
    logic [OW-1:0]        offset_q, offset_d, tailer_q, tailer_d, shift_q, shift_d;
    logic [BeatWidth-1:0] beats_q, beats_d;
    logic [SW-1:0]        stall_q, stall_d;
    logic [1:0]           resp_q, resp_d;
    logic                 first_q, first_d, err_q, err_d;

    logic                   streaming, last_beat, in_ready, accept, rx_v, rx_e;
    logic [StrbWidth-1:0]   first_m, last_m, raw_m, mask_in;
    logic [2*StrbWidth-1:0] dbl_m;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            chan_q   <= '0;
            offset_q <= '0;
            tailer_q <= '0;
            shift_q  <= '0;
            beats_q  <= '0;
            stall_q  <= '0;
            resp_q   <= '0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            offset_q <= offset_d;
            tailer_q <= tailer_d;
            shift_q  <= shift_d;
            beats_q  <= beats_d;
            stall_q  <= stall_d;
            resp_q   <= resp_d;
            first_q  <= first_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        offset_d = offset_q;
        tailer_d = tailer_q;
        shift_d  = shift_q;
        beats_d  = beats_q;
        stall_d  = stall_q;
        resp_d   = resp_q;
        first_d  = first_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (r_dp_valid_i) begin
                chan_d   = r_dp_chan_i;
                offset_d = r_dp_offset_i;
                tailer_d = r_dp_tailer_i;
                shift_d  = r_dp_shift_i;
                beats_d  = r_dp_beats_i == '0 ? BeatWidth'(1) : r_dp_beats_i;
                first_d  = 1'b1;
                err_d    = 1'b0;
                stall_d  = '0;
                resp_d   = 2'b11;
                state_d  = int'(r_dp_chan_i) < NumChan ? STREAM : RESP;
            end
            STREAM: if (accept) begin
                beats_d = beats_q - BeatWidth'(1);
                first_d = 1'b0;
                err_d   = err_q | rx_e;
                stall_d = '0;
                resp_d  = (err_q | rx_e) ? 2'b10 : 2'b00;
                state_d = last_beat ? RESP : STREAM;
            end else begin
                stall_d = stall_q + SW'(stall_q != '1);
                // registered count: abort one cycle after the limit is reached
                if (TimeoutCycles != 0 && stall_q == SW'(TimeoutCycles)) begin
                    resp_d  = 2'b11;
                    state_d = RESP;
                end
            end
            RESP: if (r_dp_rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buffer_in_o = '0;
        rx_v = 1'b0;
        rx_e = 1'b0;
        for (int c = 0; c < NumChan; c++) begin
            if (chan_q == CW'(c)) begin
                buffer_in_o = rx_data_i[c*DW +: DW];
                rx_v = rx_valid_i[c];
                rx_e = rx_err_i[c];
            end
        end
        streaming = ~rst_i & (state_q == STREAM);
        last_beat = beats_q == BeatWidth'(1);
        first_m = {StrbWidth{1'b1}} << offset_q;
        last_m = tailer_q != '0 ? {StrbWidth{1'b1}} >> (StrbWidth - int'(tailer_q)) : '1;
        raw_m = (first_q ? first_m : '1) & (last_beat ? last_m : '1);
        dbl_m = {raw_m, raw_m} >> shift_q;
        mask_in = dbl_m[StrbWidth-1:0];
        in_ready = &(buffer_in_ready_i | ~mask_in);
        accept = streaming & rx_v & in_ready;
        for (int c = 0; c < NumChan; c++) rx_ready_o[c] = streaming & (chan_q == CW'(c)) & in_ready;
        buffer_in_valid_o = accept ? mask_in : '0;
        r_dp_ready_o = ~rst_i & (state_q == IDLE);
        r_dp_rsp_valid_o = ~rst_i & (state_q == RESP);
        r_dp_rsp_resp_o = r_dp_rsp_valid_o ? resp_q : 2'b00;
    end
endmodule

// File: tb/tb_idma_txrx_read_mc.sv
// tb_idma_txrx_read_mc: scoreboard bench for the multi-channel read backend
module tb_idma_txrx_read_mc;
    localparam int SB = 16;
    localparam int NC = 3;
    localparam int DWB = 8 * SB;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              r_dp_valid_i = 1'b0;
    logic              r_dp_ready_o;
    logic [1:0]        r_dp_chan_i = '0;
    logic [3:0]        r_dp_offset_i = '0, r_dp_tailer_i = '0, r_dp_shift_i = '0;
    logic [7:0]        r_dp_beats_i = '0;
    logic [NC-1:0]     rx_valid_i = '0, rx_ready_o, rx_err_i = '0;
    logic [NC*DWB-1:0] rx_data_i = '0;
    logic [DWB-1:0]    buffer_in_o;
    logic [SB-1:0]     buffer_in_valid_o, buffer_in_ready_i = '1;
    logic              r_dp_rsp_valid_o, r_dp_rsp_ready_i = 1'b0;
    logic [1:0]        r_dp_rsp_resp_o;

    int checks = 0;
    int passes = 0;
    logic [SB-1:0] exp_mask_q[$];
    logic [1:0]    exp_rsp_q[$];

    idma_txrx_read_mc #(.StrbWidth(SB), .NumChan(NC), .BeatWidth(8), .TimeoutCycles(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .r_dp_valid_i(r_dp_valid_i), .r_dp_ready_o(r_dp_ready_o),
        .r_dp_chan_i(r_dp_chan_i), .r_dp_offset_i(r_dp_offset_i),
        .r_dp_tailer_i(r_dp_tailer_i), .r_dp_shift_i(r_dp_shift_i), .r_dp_beats_i(r_dp_beats_i),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i), .rx_err_i(rx_err_i),
        .buffer_in_o(buffer_in_o), .buffer_in_valid_o(buffer_in_valid_o), .buffer_in_ready_i(buffer_in_ready_i),
        .r_dp_rsp_valid_o(r_dp_rsp_valid_o), .r_dp_rsp_ready_i(r_dp_rsp_ready_i), .r_dp_rsp_resp_o(r_dp_rsp_resp_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // per-byte view: valid if past the offset on the first beat and below the tailer on the last
    function automatic logic [SB-1:0] model(input int off, input int tl, input int sh, input int nb, input int i);
        logic [SB-1:0] raw, r;
        int last;
        last = (nb == 0 ? 1 : nb) - 1;
        for (int j = 0; j < SB; j++) raw[j] = (i != 0 || j >= off) && (i != last || tl == 0 || j < tl);
        for (int k = 0; k < SB; k++) r[k] = raw[(k + sh) % SB];
        return r;
    endfunction

    task automatic req(input int ch, input int off, input int tl, input int sh, input int nb, input logic [1:0] er);
        @(negedge clk);
        r_dp_valid_i = 1'b1;
        r_dp_chan_i = 2'(ch);
        r_dp_offset_i = 4'(off);
        r_dp_tailer_i = 4'(tl);
        r_dp_shift_i = 4'(sh);
        r_dp_beats_i = 8'(nb);
        exp_rsp_q.push_back(er);
        #1;
        checks++;
        if (r_dp_ready_o !== 1'b1) $display("FAIL req_ready got %b want 1", r_dp_ready_o); else passes++;
        @(negedge clk);
        r_dp_valid_i = 1'b0;
    endtask

    task automatic beats(input int ch, input int off, input int tl, input int sh, input int nb, input int nd, input int eidx);
        logic [DWB-1:0] d;
        logic [SB-1:0] m;
        int w;
        for (int i = 0; i < nd; i++) begin
            for (int c = 0; c < NC; c++) rx_data_i[c*DWB +: DWB] = {$urandom, $urandom, $urandom, $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            rx_data_i[ch*DWB +: DWB] = d;
            rx_valid_i = '1;
            rx_err_i = (i == eidx) ? NC'(1 << ch) : ~NC'(1 << ch);
            exp_mask_q.push_back(model(off, tl, sh, nb, i));
            #1;
            w = 0;
            while (buffer_in_valid_o === '0 && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            m = exp_mask_q.pop_front();
            checks++;
            if (buffer_in_valid_o !== m) $display("FAIL beat%0d_mask got %h want %h", i, buffer_in_valid_o, m); else passes++;
            checks++;
            if (buffer_in_o !== d) $display("FAIL beat%0d_data got %h want %h", i, buffer_in_o, d); else passes++;
            checks++;
            if (rx_ready_o !== NC'(1 << ch)) $display("FAIL beat%0d_rx_ready got %b want %b", i, rx_ready_o, NC'(1 << ch)); else passes++;
            @(negedge clk);
        end
        rx_valid_i = '0;
        rx_err_i = '0;
    endtask

    task automatic rsp(input int exp_wait);
        logic [1:0] e;
        int w;
        e = exp_rsp_q.pop_front();
        #1;
        w = 0;
        while (r_dp_rsp_valid_o !== 1'b1 && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        checks++;
        if (w !== exp_wait) $display("FAIL rsp_latency got %0d want %0d", w, exp_wait); else passes++;
        checks++;
        if (r_dp_rsp_resp_o !== e) $display("FAIL rsp_resp got %b want %b", r_dp_rsp_resp_o, e); else passes++;
        r_dp_rsp_ready_i = 1'b1;
        @(negedge clk);
        r_dp_rsp_ready_i = 1'b0;
        #1;
        checks++;
        if ({r_dp_ready_o, r_dp_rsp_valid_o} !== 2'b10) $display("FAIL rsp_to_idle got %b want 10", {r_dp_ready_o, r_dp_rsp_valid_o}); else passes++;
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({r_dp_ready_o, rx_ready_o, buffer_in_valid_o, r_dp_rsp_valid_o, r_dp_rsp_resp_o} !== '0)
            $display("FAIL %s_outputs got %b/%b/%h/%b/%b want all 0", nm, r_dp_ready_o, rx_ready_o,
                     buffer_in_valid_o, r_dp_rsp_valid_o, r_dp_rsp_resp_o);
        else passes++;
    endtask

    task automatic test_reset;
        rx_valid_i = '1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_zero("reset");
        rst_i = 1'b0;
        rx_valid_i = '0;
        #1;
        checks++;
        if (r_dp_ready_o !== 1'b1) $display("FAIL reset_idle_ready got %b want 1", r_dp_ready_o); else passes++;
    endtask

    task automatic test_single;
        req(1, 3, 10, 0, 1, 2'b00);
        beats(1, 3, 10, 0, 1, 1, -1);
        rsp(0);
    endtask

    task automatic test_multi;
        req(0, 4, 0, 2, 4, 2'b00);
        beats(0, 4, 0, 2, 4, 4, -1);
        rsp(0);
    endtask

    task automatic test_error;
        req(1, 0, 5, 7, 3, 2'b10);
        beats(1, 0, 5, 7, 3, 3, 1);
        rsp(0);
    endtask

    task automatic test_timeout;
        req(0, 2, 0, 0, 2, 2'b11);
        beats(0, 2, 0, 0, 2, 1, -1);
        rsp(9);
        req(1, 0, 0, 0, 1, 2'b00);
        beats(1, 0, 0, 0, 1, 1, -1);
        rsp(0);
    endtask

    task automatic test_partial_ready;
        req(0, 8, 0, 0, 1, 2'b00);
        buffer_in_ready_i = 16'h00FF;
        rx_valid_i = 3'b001;
        #1;
        checks++;
        if ({rx_ready_o, buffer_in_valid_o} !== 19'h0) $display("FAIL partial_stall got %b/%h want 0/0000", rx_ready_o, buffer_in_valid_o); else passes++;
        @(negedge clk);
        buffer_in_ready_i = 16'hFFFF;
        #1;
        checks++;
        if (buffer_in_valid_o !== 16'hFF00) $display("FAIL partial_push got %h want ff00", buffer_in_valid_o); else passes++;
        checks++;
        if (rx_ready_o !== 3'b001) $display("FAIL partial_rx_ready got %b want 001", rx_ready_o); else passes++;
        @(negedge clk);
        rx_valid_i = '0;
        rsp(0);
    endtask

    task automatic test_back_to_back;
        req(2, 5, 0, 3, 0, 2'b00);
        beats(2, 5, 0, 3, 0, 1, -1);
        rsp(0);
        req(0, 1, 15, 9, 2, 2'b00);
        beats(0, 1, 15, 9, 2, 2, -1);
        rsp(0);
    endtask

    task automatic test_reset_mid;
        req(1, 0, 0, 0, 5, 2'b00);
        beats(1, 0, 0, 0, 5, 1, -1);
        rx_valid_i = '1;
        rst_i = 1'b1;
        #1;
        check_zero("rst_stream");
        @(negedge clk);
        rst_i = 1'b0;
        rx_valid_i = '0;
        exp_rsp_q.delete();
        #1;
        checks++;
        if ({r_dp_ready_o, r_dp_rsp_valid_o} !== 2'b10) $display("FAIL rst_stream_idle got %b want 10", {r_dp_ready_o, r_dp_rsp_valid_o}); else passes++;
        req(0, 0, 0, 0, 1, 2'b00);
        beats(0, 0, 0, 0, 1, 1, -1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({r_dp_rsp_valid_o, r_dp_rsp_resp_o} !== 3'b100) $display("FAIL resp_hold got %b want 100", {r_dp_rsp_valid_o, r_dp_rsp_resp_o}); else passes++;
        rst_i = 1'b1;
        #1;
        check_zero("rst_resp");
        @(negedge clk);
        rst_i = 1'b0;
        exp_rsp_q.delete();
        #1;
        checks++;
        if ({r_dp_ready_o, r_dp_rsp_valid_o} !== 2'b10) $display("FAIL rst_resp_idle got %b want 10", {r_dp_ready_o, r_dp_rsp_valid_o}); else passes++;
        req(1, 6, 3, 1, 2, 2'b00);
        beats(1, 6, 3, 1, 2, 2, -1);
        rsp(0);
    endtask

    task automatic test_bad_chan;
        rx_valid_i = '1;
        req(3, 0, 0, 0, 2, 2'b11);
        #1;
        checks++;
        if ({rx_ready_o, buffer_in_valid_o} !== 19'h0) $display("FAIL bad_chan_rx got %b/%h want 0/0000", rx_ready_o, buffer_in_valid_o); else passes++;
        rsp(0);
        rx_valid_i = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi;
        test_error;
        test_timeout;
        test_partial_ready;
        test_back_to_back;
        test_reset_mid;
        test_bad_chan;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
